// File: rtl/fft_bfly_addr_gen.sv
// Butterfly control/address generator for the in-place radix-2 DIT FFT.
// Ports: clk, rst_n (sync, active-low), start, bfly_ready -> tf_index,
//   tf_en (ROM issue), addr_a, addr_b, stage, bfly_valid, stage_last,
//   busy, done. `FFT_ADDR_GEN_STALL_CNT_EN adds stall_cycles[15:0].
module fft_bfly_addr_gen #(
  parameter int LOG2N     = 8,
  parameter int STAGE_GAP = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               bfly_ready,
  output logic [LOG2N-2:0]   tf_index,
  output logic               tf_en,
  output logic [LOG2N-1:0]   addr_a,
  output logic [LOG2N-1:0]   addr_b,
  output logic [$clog2(LOG2N)-1:0] stage,
  output logic               bfly_valid,
  output logic               stage_last,
  output logic               busy,
  output logic               done
`ifdef FFT_ADDR_GEN_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cycles
`endif
);

  localparam int AW = LOG2N;
  localparam int TW = LOG2N - 1;
  localparam int SW = $clog2(LOG2N);
  localparam int GW = $clog2(STAGE_GAP + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);

  logic [1:0]    state;
  logic [SW-1:0] s;
  logic [TW-1:0] j;
  logic [GW-1:0] gap_cnt;

  logic          issue;
  logic          j_last;

  logic [AW-1:0] span;
  logic [AW-1:0] j_ext;
  logic [AW-1:0] pos;
  logic [AW-1:0] grp_hi;
  logic [AW-1:0] a_nxt;
  logic [AW-1:0] b_nxt;
  logic [AW-1:0] tf_wide;
  logic [SW:0]   s_p1;
  logic [SW:0]   tf_sh;

  logic [AW-1:0] s1_a;
  logic [AW-1:0] s1_b;
  logic [SW-1:0] s1_s;
  logic          s1_last;

  assign issue  = (state == ST_RUN) && bfly_ready;
  assign j_last = (j == {TW{1'b1}});

  // Operand addresses insert a zero bit at position s of j; the twiddle
  // index scales the in-group position up to the 7-bit ROM range.
  always_comb begin
    span    = AW'(1) << s;
    j_ext   = AW'(j);
    pos     = j_ext & (span - AW'(1));
    s_p1    = (SW+1)'(s) + (SW+1)'(1);
    grp_hi  = (j_ext >> s) << s_p1;
    a_nxt   = grp_hi | pos;
    b_nxt   = a_nxt + span;
    tf_sh   = (SW+1)'(TW) - (SW+1)'(s);
    tf_wide = pos << tf_sh;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      s       <= '0;
      j       <= '0;
      gap_cnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            s     <= '0;
            j     <= '0;
          end
        end
        ST_RUN: begin
          if (bfly_ready) begin
            j <= j + TW'(1);
            if (j_last) begin
              state   <= ST_GAP;
              gap_cnt <= GW'(STAGE_GAP);
            end
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt - GW'(1);
          if (gap_cnt == GW'(1)) begin
            if (s == S_LAST) begin
              state <= ST_DONE;
            end else begin
              state <= ST_RUN;
              s     <= s + SW'(1);
              j     <= '0;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // S1: ROM issue stage; S2: addresses aligned with the ROM output.
  always_ff @(posedge clk) begin
    if (!rst_n || !issue) begin
      tf_en    <= 1'b0;
      tf_index <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_s     <= '0;
      s1_last  <= 1'b0;
    end else begin
      tf_en    <= 1'b1;
      tf_index <= tf_wide[TW-1:0];
      s1_a     <= a_nxt;
      s1_b     <= b_nxt;
      s1_s     <= s;
      s1_last  <= j_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !tf_en) begin
      bfly_valid <= 1'b0;
      addr_a     <= '0;
      addr_b     <= '0;
      stage      <= '0;
      stage_last <= 1'b0;
    end else begin
      bfly_valid <= 1'b1;
      addr_a     <= s1_a;
      addr_b     <= s1_b;
      stage      <= s1_s;
      stage_last <= s1_last;
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

`ifdef FFT_ADDR_GEN_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (state == ST_IDLE && start) begin
      stall_cycles <= '0;
    end else if (state == ST_RUN && !bfly_ready
                 && stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_bfly_addr_gen.sv
// Self-checking bench for fft_bfly_addr_gen: randomized/directed ready
// patterns checked cycle by cycle against a beat-list reference model.
module tb_fft_bfly_addr_gen;

  localparam int GAP = 4;
  localparam int NB  = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       bfly_ready = 1'b0;
  logic [6:0] tf_index;
  logic       tf_en;
  logic [7:0] addr_a;
  logic [7:0] addr_b;
  logic [2:0] stage;
  logic       bfly_valid;
  logic       stage_last;
  logic       busy;
  logic       done;
`ifdef FFT_ADDR_GEN_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  fft_bfly_addr_gen #(.LOG2N(8), .STAGE_GAP(GAP)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .bfly_ready(bfly_ready),
    .tf_index(tf_index),
    .tf_en(tf_en),
    .addr_a(addr_a),
    .addr_b(addr_b),
    .stage(stage),
    .bfly_valid(bfly_valid),
    .stage_last(stage_last),
    .busy(busy),
    .done(done)
`ifdef FFT_ADDR_GEN_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  int compared = 0;
  int mismatched = 0;

  int exp_a  [NB];
  int exp_b  [NB];
  int exp_tf [NB];
  int exp_s  [NB];
  int exp_l  [NB];
  int obs_a  [NB];
  int obs_b  [NB];
  int obs_tf [NB];

  // model: phase 0 idle, 1 issuing, 2 draining, 3 done
  int ph = 0;
  int ptr = 0;
  int mg = 0;
  int p1v = 0;
  int p1i = 0;
  int p2v = 0;
  int p2i = 0;
  int m_stall = 0;

  int n_tf, n_last, n_val, done_cyc, cur;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] ex);
    compared++;
    assert (obs === ex) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, ex);
    end
  endtask

  task automatic check_all();
    chk("tf_en", 32'(tf_en), 32'(p1v));
    chk("tf_index", 32'(tf_index), p1v != 0 ? exp_tf[p1i] : 0);
    chk("bfly_valid", 32'(bfly_valid), 32'(p2v));
    chk("addr_a", 32'(addr_a), p2v != 0 ? exp_a[p2i] : 0);
    chk("addr_b", 32'(addr_b), p2v != 0 ? exp_b[p2i] : 0);
    chk("stage", 32'(stage), p2v != 0 ? exp_s[p2i] : 0);
    chk("stage_last", 32'(stage_last), p2v != 0 ? exp_l[p2i] : 0);
    chk("busy", 32'(busy), 32'(ph != 0));
    chk("done", 32'(done), 32'(ph == 3));
`ifdef FFT_ADDR_GEN_STALL_CNT_EN
    chk("stall_cycles", 32'(stall_cycles), m_stall);
`endif
  endtask

  task automatic step(input logic st, input logic rdy, input logic rn);
    start = st;
    bfly_ready = rdy;
    rst_n = rn;
    @(posedge clk);
    if (!rn) begin
      ph = 0; p1v = 0; p2v = 0; m_stall = 0;
    end else begin
      p2v = p1v; p2i = p1i;
      p1v = (ph == 1 && rdy) ? 1 : 0;
      p1i = ptr;
      if (ph == 0 && st) m_stall = 0;
      else if (ph == 1 && !rdy && m_stall < 65535) m_stall++;
      case (ph)
        0: if (st) begin ph = 1; ptr = 0; end
        1: if (rdy) begin
             ptr++;
             if (ptr % 128 == 0) begin ph = 2; mg = GAP; end
           end
        2: begin
             mg--;
             if (mg == 0) ph = (ptr == NB) ? 3 : 1;
           end
        default: ph = 0;
      endcase
    end
    #1;
    cur++;
    if (tf_en === 1'b1) begin
      if (n_tf < NB) obs_tf[n_tf] = 32'(tf_index);
      n_tf++;
    end
    if (bfly_valid === 1'b1) begin
      if (n_val < NB) begin
        obs_a[n_val] = 32'(addr_a);
        obs_b[n_val] = 32'(addr_b);
      end
      n_val++;
    end
    if (stage_last === 1'b1) n_last++;
    if (done === 1'b1 && done_cyc < 0) done_cyc = cur;
    check_all();
  endtask

  // mode 0: always ready; 1: pattern 1,0,0,1; 2: random; 3: 2x5 lows
  task automatic run_one(input int mode, input int abort_at,
                         input bit noisy);
    int k = 0;
    int l1 = 0;
    int l2 = 0;
    bit fin = 0;
    logic rdy, st, rn;
    n_tf = 0; n_last = 0; n_val = 0; done_cyc = -1; cur = 0;
    step(1'b1, 1'b1, 1'b1);
    chk("busy_after_start", 32'(busy), 1);
    while (!fin && k < 6000) begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (k % 4 == 0 || k % 4 == 3);
        2: rdy = 1'($urandom % 2);
        default: begin
          rdy = 1'b1;
          if (ph == 1 && ptr == 120 && l1 < 5) begin rdy = 0; l1++; end
          if (ph == 1 && ptr == 130 && l2 < 5) begin rdy = 0; l2++; end
        end
      endcase
      st = noisy && ptr >= 256 && ptr < 384 && ($urandom % 3 == 0);
      rn = !(abort_at >= 0 && ptr >= abort_at);
      step(st, rdy, rn);
      if (done === 1'b1 || !rn) fin = 1;
      k++;
    end
    chk("run_finished", 32'(fin), 1);
    if (abort_at < 0) begin
      chk("tf_en_count", n_tf, NB);
      chk("bfly_valid_count", n_val, NB);
      chk("stage_last_count", n_last, 8);
      if (mode == 0) chk("done_cycle", done_cyc, 1057);
    end else begin
      chk("abort_no_done", 32'(done_cyc), 32'(-1));
    end
  endtask

  initial begin
    for (int i = 0; i < NB; i++) begin
      int s, j, span;
      s = i / 128;
      j = i % 128;
      span = 1 << s;
      exp_s[i]  = s;
      exp_a[i]  = (j / span) * 2 * span + (j % span);
      exp_b[i]  = exp_a[i] + span;
      exp_tf[i] = (j % span) * (128 / span);
      exp_l[i]  = (j == 127) ? 1 : 0;
    end

    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_tf_en", 32'(tf_en), 0);

    run_one(0, -1, 0);
    chk("spot_s0_a", obs_a[5], 10);
    chk("spot_s0_b", obs_b[5], 11);
    chk("spot_s0_tf", obs_tf[77], 0);
    chk("spot_s3_a", obs_a[3*128+13], 21);
    chk("spot_s3_b", obs_b[3*128+13], 29);
    chk("spot_s3_tf", obs_tf[3*128+13], 80);
    chk("spot_s7_a", obs_a[7*128+100], 100);
    chk("spot_s7_b", obs_b[7*128+100], 228);
    chk("spot_s7_tf", obs_tf[7*128+100], 100);
    chk("spot_s1_a", obs_a[1*128+127], 253);
    chk("spot_s1_b", obs_b[1*128+127], 255);
    chk("spot_s1_tf", obs_tf[1*128+127], 64);

    step(1'b0, 1'b1, 1'b1);
    run_one(1, -1, 0);
    step(1'b0, 1'b0, 1'b1);
    run_one(2, -1, 1);
    step(1'b0, 1'b1, 1'b1);
    run_one(0, 4*128+50, 0);
    step(1'b0, 1'b1, 1'b1);
    chk("post_abort_busy", 32'(busy), 0);
    run_one(0, -1, 0);
    chk("restart_a0", obs_a[0], 0);
    chk("restart_b0", obs_b[0], 1);

    step(1'b0, 1'b1, 1'b1);
    run_one(3, -1, 0);
`ifdef FFT_ADDR_GEN_STALL_CNT_EN
    chk("stall_at_done", 32'(stall_cycles), 10);
    step(1'b0, 1'b1, 1'b1);
    chk("stall_hold_idle", 32'(stall_cycles), 10);
    step(1'b1, 1'b1, 1'b1);
    chk("stall_cleared", 32'(stall_cycles), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
